// File: rtl/sha256_round_engine.sv
// Iterative SHA-256 compression core: one 512-bit block per job, one round per clock.
// Optional macro SHA256_IV_SEL_EN adds a use_iv input that selects the FIPS 180-4 IV instead of hash_in.
module sha256_round_engine #(
  parameter int unsigned ROUNDS = 64,
  parameter int unsigned CNT_W  = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef SHA256_IV_SEL_EN
  input  logic         use_iv,
`endif
  input  logic [511:0] block_in,
  input  logic [255:0] hash_in,
  output logic         ready,
  output logic         digest_valid,
  output logic [255:0] digest_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_s0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_s1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       hv [8];
  logic [31:0]       a, b, c, d, e, f, g, h;
  logic [31:0]       w [16];

  logic [255:0]      init_h;
  logic [5:0]        k_idx;
  logic [31:0]       k;
  logic [31:0]       t1, t2;
  logic [31:0]       w_new;
  logic              last_round;

  always_comb begin
    init_h = hash_in;
`ifdef SHA256_IV_SEL_EN
    if (use_iv) init_h = SHA256_IV;
`endif
  end

  always_comb begin
    k_idx      = 6'(cnt);
    k          = K_ROM[k_idx];
    t1         = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + w[0];
    t2         = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
    // window holds W[cnt..cnt+15]; this produces W[cnt+16]
    w_new      = small_s1(w[14]) + w[9] + small_s0(w[1]) + w[0];
    last_round = (cnt == CNT_W'(ROUNDS - 1));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ROUND;
      ROUND:   if (last_round) state_next = FINAL;
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      digest_valid <= 1'b0;
      digest_out   <= '0;
      {a, b, c, d, e, f, g, h} <= '0;
      for (int unsigned i = 0; i < 8; i++) hv[i] <= '0;
      for (int unsigned i = 0; i < 16; i++) w[i] <= '0;
    end else begin
      state        <= state_next;
      digest_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < 8; i++) hv[i] <= init_h[255 - 32*i -: 32];
            {a, b, c, d, e, f, g, h} <= init_h;
            for (int unsigned i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
            cnt <= '0;
          end
        end
        ROUND: begin
          h <= g;
          g <= f;
          f <= e;
          e <= d + t1;
          d <= c;
          c <= b;
          b <= a;
          a <= t1 + t2;
          for (int unsigned i = 0; i < 15; i++) w[i] <= w[i + 1];
          w[15] <= w_new;
          cnt   <= cnt + 1'b1;
        end
        FINAL: begin
          digest_out   <= {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
                           hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
          digest_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
// Directed bench for sha256_round_engine using the FIPS 180-4 "abc", empty and two-block vectors.
module tb_sha256_round_engine;

  localparam logic [255:0] IV =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    256'h6162636462636465636465666465666765666768666768696768696a68696a6b,
    256'h696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f70718000000000000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] DG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DG_TWO_MID =
    256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] DG_TWO =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
`ifdef SHA256_IV_SEL_EN
  logic         use_iv;
`endif
  logic [511:0] block_in;
  logic [255:0] hash_in;
  logic         ready;
  logic         digest_valid;
  logic [255:0] digest_out;

  int passes = 0;
  int fails  = 0;
  int total  = 0;
  int lat;

  sha256_round_engine #(.ROUNDS(64), .CNT_W(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
`ifdef SHA256_IV_SEL_EN
    .use_iv       (use_iv),
`endif
    .block_in     (block_in),
    .hash_in      (hash_in),
    .ready        (ready),
    .digest_valid (digest_valid),
    .digest_out   (digest_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  // counts edges after the accepting edge until digest_valid is seen (bounded)
  task automatic wait_done(output int n);
    n = 0;
    while (!digest_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic launch(input logic [511:0] blk, input logic [255:0] hv);
    block_in = blk;
    hash_in  = hv;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    block_in = ~blk;
    hash_in  = ~hv;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    block_in = '0;
    hash_in  = '0;
`ifdef SHA256_IV_SEL_EN
    use_iv   = 1'b0;
`endif
    tick();
    tick();
    check("rst_ready", 256'(ready), 256'd1);
    check("rst_valid", 256'(digest_valid), 256'd0);
    check("rst_digest", digest_out, 256'd0);
    rst_n = 1'b1;
    tick();

    launch(BLK_ABC, IV);
    check("abc_busy", 256'(ready), 256'd0);
    wait_done(lat);
    check("abc_latency", 256'(lat), 256'd65);
    check("abc_digest", digest_out, DG_ABC);
    check("abc_ready_in_valid", 256'(ready), 256'd1);
    tick();
    check("abc_valid_pulse", 256'(digest_valid), 256'd0);
    check("abc_digest_held", digest_out, DG_ABC);

    launch(BLK_EMPTY, IV);
    wait_done(lat);
    check("empty_latency", 256'(lat), 256'd65);
    check("empty_digest", digest_out, DG_EMPTY);
    tick();

    launch(BLK_TWO1, IV);
    wait_done(lat);
    check("two_mid_latency", 256'(lat), 256'd65);
    check("two_mid_digest", digest_out, DG_TWO_MID);
    // second block accepted in the digest_valid cycle, chained from the first digest
    block_in = BLK_TWO2;
    hash_in  = digest_out;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    block_in = '1;
    hash_in  = '1;
    check("two_no_gap", 256'(ready), 256'd0);
    check("two_valid_drop", 256'(digest_valid), 256'd0);
    check("two_mid_held", digest_out, DG_TWO_MID);
    wait_done(lat);
    check("two_latency", 256'(lat), 256'd65);
    check("two_digest", digest_out, DG_TWO);
    tick();

    block_in = BLK_ABC;
    hash_in  = IV;
    start    = 1'b1;
    tick();
    block_in = BLK_EMPTY;
    hash_in  = '1;
    lat = 0;
    while (!digest_valid && lat < 200) begin
      if (lat == 40) start = 1'b0;
      tick();
      lat++;
      if (lat == 10) check("spam_busy", 256'(ready), 256'd0);
    end
    check("spam_latency", 256'(lat), 256'd65);
    check("spam_digest", digest_out, DG_ABC);
    tick();
    check("spam_idle_after", 256'(ready), 256'd1);

    launch(BLK_EMPTY, IV);
    for (int i = 0; i < 30; i++) begin
      start = 1'b1;
      tick();
    end
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    check("abort_ready", 256'(ready), 256'd1);
    check("abort_valid", 256'(digest_valid), 256'd0);
    check("abort_digest", digest_out, 256'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) tick();
    check("abort_no_late_valid", 256'(digest_valid), 256'd0);
    check("abort_digest_stays", digest_out, 256'd0);

    launch(BLK_ABC, IV);
    wait_done(lat);
    check("post_abort_latency", 256'(lat), 256'd65);
    check("post_abort_digest", digest_out, DG_ABC);
    tick();

`ifdef SHA256_IV_SEL_EN
    use_iv = 1'b1;
    launch(BLK_ABC, '1);
    use_iv = 1'b0;
    wait_done(lat);
    check("iv_sel_latency", 256'(lat), 256'd65);
    check("iv_sel_digest", digest_out, DG_ABC);
    tick();
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
